conv_core_param: RTL and testbench

// Parametrised KxK convolution core computing NUM_FILT output channels per window, one window per cycle.

---
 rtl/conv_core_param_if.sv | 29 ++
 rtl/conv_core_param.sv | 118 +++++++++++
 tb/tb_conv_core_param.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_core_param_if.sv
// conv_core_param_if: weight-memory, activation-window and result bus of the convolution core
interface conv_core_param_if #(
    parameter int DATA_W   = 8,
    parameter int K        = 3,
    parameter int NUM_FILT = 4,
    parameter int WADDR_W  = 10
);
    logic                         load_start;
    logic                         addr_rst;
    logic                         w_rd_en;
    logic [WADDR_W-1:0]           w_addr;
    logic signed [DATA_W-1:0]     w_rdata;
    logic                         weight_done;
    logic                         activate_ready;
    logic [K*K*DATA_W-1:0]        act_win;
    logic                         relu_en;
    logic [NUM_FILT*DATA_W-1:0]   out_psum;
    logic                         out_psum_vld;

    modport slave (
        input  load_start, addr_rst, w_rdata, activate_ready, act_win, relu_en,
        output w_rd_en, w_addr, weight_done, out_psum, out_psum_vld
    );

    modport master (
        output load_start, addr_rst, w_rdata, activate_ready, act_win, relu_en,
        input  w_rd_en, w_addr, weight_done, out_psum, out_psum_vld
    );
endinterface

// File: rtl/conv_core_param.sv
// conv_core_param: KxK multi-filter convolution core with weight loader and 3-stage MAC pipeline
module conv_core_param #(
    parameter int DATA_W    = 8,
    parameter int K         = 3,
    parameter int NUM_FILT  = 4,
    parameter int OUT_SHIFT = 0,
    parameter int WADDR_W   = 10
) (
    input logic clk,
    input logic rst,
    conv_core_param_if.slave io_bus
);
    localparam int KK    = K * K;
    localparam int N     = NUM_FILT * KK;
    localparam int IW    = $clog2(N + 1);
    localparam int PW    = 2 * DATA_W + 1;
    localparam int ACC_W = PW + $clog2(KK);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t                     r_st, w_nxt;
    logic [IW-1:0]              r_idx, r_cap_idx;
    logic [WADDR_W-1:0]         r_base;
    logic                       r_cap_vld;
    logic signed [DATA_W-1:0]   r_wgt [N];
    logic                       w_start, w_fin, w_acc;
    logic                       r_v0, r_v1, r_v2, r_vld;
    logic                       r_relu0, r_relu1, r_relu2;
    logic [KK*DATA_W-1:0]       r_act;
    logic signed [PW-1:0]       r_prod [NUM_FILT][KK];
    logic signed [ACC_W-1:0]    w_sum [NUM_FILT];
    logic signed [ACC_W-1:0]    r_sum [NUM_FILT];
    logic signed [ACC_W-1:0]    w_a, w_v;
    logic [NUM_FILT*DATA_W-1:0] w_res, r_out;

    assign w_start             = r_st != LOAD && io_bus.load_start;
    assign w_fin               = r_st == LOAD && r_cap_vld && r_cap_idx == IW'(N - 1);
    assign w_acc               = r_st == READY && io_bus.activate_ready;
    assign io_bus.w_rd_en      = r_st == LOAD && r_idx != IW'(N);
    assign io_bus.w_addr       = r_base + WADDR_W'(r_idx);
    assign io_bus.weight_done  = r_st == READY;
    assign io_bus.out_psum     = r_out;
    assign io_bus.out_psum_vld = r_vld;

    always_comb begin
        w_nxt = r_st;
        if (w_start)
            w_nxt = LOAD;
        else if (w_fin)
            w_nxt = READY;
    end

    // memory returns data one cycle after the read, so capture trails the address by one slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= IDLE;
            r_idx     <= '0;
            r_base    <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_vld     <= 1'b0;
            r_out     <= '0;
            for (int i = 0; i < N; i++)
                r_wgt[i] <= '0;
        end else begin
            r_st      <= w_nxt;
            r_idx     <= w_start ? '0 : (io_bus.w_rd_en ? r_idx + 1'b1 : r_idx);
            r_base    <= w_fin ? r_base + WADDR_W'(N) : ((r_st != LOAD && io_bus.addr_rst) ? '0 : r_base);
            r_cap_vld <= io_bus.w_rd_en;
            r_cap_idx <= r_idx;
            if (r_cap_vld)
                r_wgt[r_cap_idx] <= io_bus.w_rdata;
            r_v0      <= w_acc;
            r_v1      <= r_v0;
            r_v2      <= r_v1;
            r_vld     <= r_v2;
            if (r_v2)
                r_out <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        r_act   <= io_bus.act_win;
        r_relu0 <= io_bus.relu_en;
        r_relu1 <= r_relu0;
        r_relu2 <= r_relu1;
        for (int f = 0; f < NUM_FILT; f++) begin
            for (int e = 0; e < KK; e++)
                r_prod[f][e] <= PW'($signed({1'b0, r_act[e*DATA_W +: DATA_W]})) * PW'(r_wgt[f*KK+e]);
            r_sum[f] <= w_sum[f];
        end
    end

    always_comb begin
        w_a = '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            w_a = '0;
            for (int e = 0; e < KK; e++)
                w_a = w_a + ACC_W'(r_prod[f][e]);
            w_sum[f] = w_a;
        end
    end

    always_comb begin
        w_res = '0;
        w_v   = '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            w_v = r_sum[f] >>> OUT_SHIFT;
            w_v = (r_relu2 && w_v[ACC_W-1]) ? '0 : w_v;
            w_res[f*DATA_W +: DATA_W] = w_v > MAXV ? MAXV[DATA_W-1:0] : (w_v < MINV ? MINV[DATA_W-1:0] : w_v[DATA_W-1:0]);
        end
    end
endmodule

// File: tb/tb_conv_core_param.sv
// tb_conv_core_param: directed checks of weight load timing, compute, saturation/ReLU, streaming and base pointer
module tb_conv_core_param;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int NF = 4;
    localparam int AW = 10;
    localparam int N  = 36;

    logic clk = 0;
    logic rst = 0;
    int n_chk = 0;
    int n_err = 0;
    logic signed [7:0] mem [1024];
    int wts [N];

    conv_core_param_if #(.DATA_W(DW), .K(K), .NUM_FILT(NF), .WADDR_W(AW)) bus ();

    conv_core_param #(.DATA_W(DW), .K(K), .NUM_FILT(NF), .OUT_SHIFT(0), .WADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.w_rd_en)
            bus.w_rdata <= mem[bus.w_addr];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [71:0] act_seq(input int s);
        logic [71:0] r;
        int v;
        r = '0;
        for (int e = 0; e < 9; e++) begin
            v = s + e;
            r[e*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [71:0] a, input bit relu);
        logic [31:0] r;
        int s;
        r = '0;
        for (int f = 0; f < NF; f++) begin
            s = 0;
            for (int e = 0; e < 9; e++)
                s += int'(a[e*8 +: 8]) * wts[f*9+e];
            if (relu && s < 0) s = 0;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[f*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic load(input int base, input bit ar, input bit mid_ld, input bit mid_ar);
        @(negedge clk);
        bus.load_start = 1;
        bus.addr_rst = ar;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.load_start = mid_ld && i == 10;
            bus.addr_rst = mid_ar && i == 10;
            chk("rd_en", bus.w_rd_en, 1);
            chk("w_addr", bus.w_addr, (base + i) % 1024);
            chk("done_low", bus.weight_done, 0);
        end
        @(negedge clk);
        bus.load_start = 0;
        bus.addr_rst = 0;
        chk("rd_en_end", bus.w_rd_en, 0);
        chk("done_e36", bus.weight_done, 0);
        @(negedge clk);
        chk("done_e37", bus.weight_done, 1);
    endtask

    task automatic win(input string tag, input logic [71:0] a, input bit relu, input logic [31:0] exp);
        @(negedge clk);
        bus.act_win = a;
        bus.relu_en = relu;
        bus.activate_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.activate_ready = 0;
            chk({tag, "_vld_early"}, bus.out_psum_vld, 0);
        end
        @(negedge clk);
        chk({tag, "_vld"}, bus.out_psum_vld, 1);
        chk(tag, bus.out_psum, exp);
        @(negedge clk);
        chk({tag, "_vld_off"}, bus.out_psum_vld, 0);
        chk({tag, "_hold"}, bus.out_psum, exp);
    endtask

    task automatic stream();
        logic [71:0] a [10];
        bit rl [10];
        for (int k = 0; k < 10; k++) begin
            a[k] = act_seq(k * 3);
            rl[k] = (k % 2) == 1;
        end
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (n >= 4 && n < 14) begin
                chk("stream_vld", bus.out_psum_vld, 1);
                chk("stream_out", bus.out_psum, model(a[n-4], rl[n-4]));
            end else
                chk("stream_vld_idle", bus.out_psum_vld, 0);
            bus.activate_ready = n < 10;
            if (n < 10) begin
                bus.act_win = a[n];
                bus.relu_en = rl[n];
            end
        end
        bus.activate_ready = 0;
    endtask

    initial begin
        bus.load_start = 0;
        bus.addr_rst = 0;
        bus.activate_ready = 0;
        bus.act_win = '0;
        bus.relu_en = 0;
        #2 rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.load_start = 1'($urandom);
            bus.addr_rst = 1'($urandom);
            bus.activate_ready = 1'($urandom);
            bus.relu_en = 1'($urandom);
            bus.act_win = {8'($urandom), $urandom, $urandom};
            chk("rst_rd_en", bus.w_rd_en, 0);
            chk("rst_addr", bus.w_addr, 0);
            chk("rst_done", bus.weight_done, 0);
            chk("rst_out", bus.out_psum, 0);
            chk("rst_vld", bus.out_psum_vld, 0);
        end
        @(negedge clk);
        bus.load_start = 0;
        bus.addr_rst = 0;
        bus.activate_ready = 1;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.act_win = {8'($urandom), $urandom, $urandom};
            chk("idle_vld", bus.out_psum_vld, 0);
            chk("idle_done", bus.weight_done, 0);
            chk("idle_rd_en", bus.w_rd_en, 0);
        end
        bus.activate_ready = 0;

        for (int i = 0; i < N; i++) begin
            mem[i] = 8'(i);
            mem[36+i] = 8'(i / 9 + 1);
            mem[72+i] = (i / 9 == 0) ? -8'sd1 : (i / 9 == 1) ? -8'sd128 : (i / 9 == 2) ? 8'sd1 : 8'sd0;
        end

        load(0, 0, 0, 0);
        win("onehot4", 72'(1) << 32, 0, pk(4, 13, 22, 31));
        win("elem0x2", 72'd2, 0, pk(0, 18, 36, 54));

        load(36, 0, 0, 0);
        win("ramp", act_seq(1), 0, pk(45, 90, 127, 127));

        load(72, 0, 0, 0);
        win("neg", act_seq(1), 0, pk(-45, -128, 45, 0));
        win("relu", act_seq(1), 1, pk(0, 0, 45, 0));
        win("sat", {9{8'hFF}}, 0, pk(-128, -128, 127, 0));

        @(negedge clk);
        bus.addr_rst = 1;
        @(negedge clk);
        bus.addr_rst = 0;
        load(0, 0, 1, 0);
        win("reload_onehot4", 72'(1) << 32, 0, pk(4, 13, 22, 31));

        for (int i = 0; i < N; i++) begin
            wts[i] = ((i / 9 + i % 9) % 5) - 2;
            mem[i] = 8'(wts[i]);
        end
        load(0, 1, 0, 1);
        stream();

        load(36, 0, 0, 0);
        win("ramp_again", act_seq(1), 0, pk(45, 90, 127, 127));

        @(negedge clk);
        bus.act_win = act_seq(1);
        bus.relu_en = 0;
        bus.activate_ready = 1;
        @(negedge clk);
        bus.activate_ready = 0;
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_vld", bus.out_psum_vld, 0);
            chk("midrst_out", bus.out_psum, 0);
            chk("midrst_done", bus.weight_done, 0);
        end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_vld", bus.out_psum_vld, 0);
            chk("postrst_done", bus.weight_done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
